// File: rtl/psec5_bank_position_counter.sv
// Per-bank 10-bit sample-position counters (A-D fast, E slow) advancing on FCLK
// while the bank's synchronized active-low TRIGGER strobe says it is sampling.
module psec5_bank_position_counter #(
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic                 FCLK,
  input  logic                 RST,
  input  logic                 CLEAR,
  input  logic                 FREEZE,
  input  logic                 TRIGGERA,
  input  logic                 TRIGGERB,
  input  logic                 TRIGGERC,
  input  logic                 TRIGGERD,
  input  logic                 TRIGGERE,
  output logic [CNT_WIDTH-1:0] CA,
  output logic [CNT_WIDTH-1:0] CB,
  output logic [CNT_WIDTH-1:0] CC,
  output logic [CNT_WIDTH-1:0] CD,
  output logic [CNT_WIDTH-1:0] CE,
  output logic [4:0]           OVF,
  output logic [4:0]           RUNNING
);

  localparam int unsigned NB = 5;

  logic [NB-1:0]          trig_in;
  logic [SYNC_STAGES-1:0] trig_sync_q [NB];
  logic [SYNC_STAGES-1:0] trig_sync_d [NB];
  logic [SYNC_STAGES-1:0] clr_sync_q;
  logic [SYNC_STAGES-1:0] clr_sync_d;
  logic                   clr_hist_q;
  logic                   clr_hist_d;
  logic                   clr_p;
  logic [NB-1:0]          run;
  logic [CNT_WIDTH-1:0]   cnt_q [NB];
  logic [CNT_WIDTH-1:0]   cnt_d [NB];
  logic [NB-1:0]          ovf_q;
  logic [NB-1:0]          ovf_d;

  assign trig_in = {TRIGGERE, TRIGGERD, TRIGGERC, TRIGGERB, TRIGGERA};

  // Synchronizers shift unconditionally so FREEZE and clear never stall them.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      trig_sync_d[i] = {trig_sync_q[i][SYNC_STAGES-2:0], trig_in[i]};
      run[i]         = ~trig_sync_q[i][SYNC_STAGES-1];
    end
    clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], CLEAR};
    clr_hist_d = clr_sync_q[SYNC_STAGES-1];
    clr_p      = clr_sync_q[SYNC_STAGES-1] & ~clr_hist_q;
  end

  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr_p) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (!FREEZE && run[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SATURATE ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NB; i++) begin
        trig_sync_q[i] <= '1;
        cnt_q[i]       <= '0;
      end
      clr_sync_q <= '0;
      clr_hist_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        trig_sync_q[i] <= trig_sync_d[i];
        cnt_q[i]       <= cnt_d[i];
      end
      clr_sync_q <= clr_sync_d;
      clr_hist_q <= clr_hist_d;
      ovf_q      <= ovf_d;
    end
  end

  assign CA      = cnt_q[0];
  assign CB      = cnt_q[1];
  assign CC      = cnt_q[2];
  assign CD      = cnt_q[3];
  assign CE      = cnt_q[4];
  assign OVF     = ovf_q;
  assign RUNNING = run;

endmodule

// File: doc/psec5_bank_position_counter.md
Name: psec5_bank_position_counter

Overview:
- Generates the five 10-bit sample-position counters CA..CE consumed by the channel digital block. There is one counter per SCA bank: A-D are fast banks, E is the slow bank.
- Each counter advances on FCLK while its bank is sampling, which is indicated by the active-low TRIGGERx strobe from the channel state machine.
- Each counter holds its value when the bank stops, so the stop position is preserved for the trigger_cnt/CA..CE readout snapshot.
- Sits directly upstream of the channel digital block's counter inputs and downstream of its TRIGGERA..TRIGGERE outputs.

Parameters:
- CNT_WIDTH, 10, width of each position counter.
- SYNC_STAGES, 2, flop stages synchronizing TRIGGERx and CLEAR into FCLK (minimum 2).
- SATURATE, 0, 0 = counter wraps modulo 2^CNT_WIDTH; 1 = counter holds at all-ones.

Ports:
- FCLK  input  1  sampling clock (5 GHz domain), rising-edge.
- RST  input  1  asynchronous, active-high reset.
- CLEAR  input  1  counter clear request (driven from INST_START); asynchronous to FCLK; held high ≥ SYNC_STAGES+1 FCLK cycles.
- FREEZE  input  1  synchronous hold of all counters (readout); already FCLK-synchronous.
- TRIGGERA  input  1  bank A run strobe; 0 = sampling; asynchronous.
- TRIGGERB  input  1  bank B run strobe; same semantics as TRIGGERA.
- TRIGGERC  input  1  bank C run strobe; same semantics as TRIGGERA.
- TRIGGERD  input  1  bank D run strobe; same semantics as TRIGGERA.
- TRIGGERE  input  1  slow bank run strobe; same semantics as TRIGGERA.
- CA  output  CNT_WIDTH  bank A position.
- CB  output  CNT_WIDTH  bank B position.
- CC  output  CNT_WIDTH  bank C position.
- CD  output  CNT_WIDTH  bank D position.
- CE  output  CNT_WIDTH  slow bank position.
- OVF  output  5  sticky per-bank overflow flags; bit0 = A … bit4 = E.
- RUNNING  output  5  synchronized run state per bank; bit0 = A … bit4 = E.

Behaviour:
- Reset (RST=1, asynchronous): CA..CE=0, OVF=0, RUNNING=0, all sync flops=1 (bank stopped), CLEAR edge-detect history=0. The block stays in this state until the first FCLK edge after RST deasserts.
- TRIGGER synchronization: each TRIGGERx passes through SYNC_STAGES flops; RUNNING[x] = inverted sync output. The synchronizers keep running during FREEZE and during the clear pulse.
- CLEAR synchronization: CLEAR passes through SYNC_STAGES flops followed by a rising-edge detector, producing clr_p, a one-cycle pulse.
- Per-counter priority per FCLK edge, highest first:
  - clr_p: counter <= 0, OVF[x] <= 0.
  - FREEZE=1: hold.
  - RUNNING[x]=1: increment.
  - otherwise: hold.
- Increment rule:
  - SATURATE=0: value 2^CNT_WIDTH-1 (1023) becomes 0 and OVF[x] <= 1.
  - SATURATE=1: value stays at 1023 and OVF[x] <= 1.
  - OVF is sticky until clr_p or RST.
- Latency:
  - TRIGGERx falling (setup met at edge 0) -> RUNNING[x]=1 after edge SYNC_STAGES-1 -> counter=1 after edge SYNC_STAGES.
  - TRIGGERx rising -> last increment on edge SYNC_STAGES-1; the counter then holds.
  - CLEAR rising -> counters=0 after edge SYNC_STAGES.
- Simultaneous events:
  - clr_p and RUNNING on the same edge: clear wins, value=0. Counting resumes on the next edge if still running.
  - clr_p and FREEZE on the same edge: clear wins.
  - CLEAR held high for a long time: only one clear occurs. CLEAR must return low for ≥ SYNC_STAGES cycles before another edge is recognised.
- Independence:
  - The banks are independent; any subset may run concurrently, e.g. SAMPLING_ALL runs A-D plus E.
  - The A->B handoff in single-bank mode produces A stopping and B starting in the same cycle. Both counters behave per their own strobe; no interlock.
- Reset mid-count: all counters go to 0 immediately and asynchronously. On release, counting resumes only after the synchronizers see TRIGGERx=0 again, i.e. the normal SYNC_STAGES-edge latency.
- Outputs CA..CE, OVF and RUNNING are registered; there are no combinational paths from inputs.
- Ports CA..CE are CNT_WIDTH wide; the channel digital block requires CNT_WIDTH=10.

Test Plan:
- Reset and idle:
  - Stimulus: RST pulse, then all TRIGGERx=1 for 50 cycles.
  - Response: CA..CE=0, OVF=0, RUNNING=0 throughout.
- Single-bank run:
  - Stimulus: TRIGGERA=0 at edge 0, raised back to 1 after 100 cycles.
  - Response: CA=1 after edge 2; RUNNING[0]=1 from edge 1; CA holds at 100; CB..CE=0.
- Wrap and saturate:
  - Stimulus: TRIGGERE=0 for 1030 cycles.
  - SATURATE=0 response: CE=1023 then 0 at the 1024th increment; OVF[4]=1; final CE=6.
  - SATURATE=1 response: CE=1023; OVF[4]=1.
- Clear versus count collision:
  - Stimulus: banks A and B running at CA=37; CLEAR held 4 cycles.
  - Response: CA=CB=0 on the clr_p edge; value=1 on the next edge; OVF cleared; exactly one clear.
- Freeze during run:
  - Stimulus: CC=200 running; FREEZE=1 for 10 cycles, then 0.
  - Response: CC stays 200 for 10 cycles, then resumes 201, 202, …; RUNNING[2] stays 1.
- Async reset mid-operation:
  - Stimulus: all banks running at ~500; RST asserted between edges, then released with TRIGGERx still 0.
  - Response: outputs 0 immediately; first increment after edge SYNC_STAGES post-release.
